// File: rtl/calc_mem_pkg.sv
// rtl/calc_mem_pkg.sv - shared state type and default sizes for calculator memories
package calc_mem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } mem_state_e;

  localparam int CALC_DATA_W = 16;
  localparam int CALC_DEPTH  = 512;
  localparam int CALC_ADDR_W = 9;

endpackage

// File: rtl/mem_clear_fsm.sv
// rtl/mem_clear_fsm.sv - clear engine: sweeps the array to zero and muxes the write port
module mem_clear_fsm
  import calc_mem_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int DEPTH  = CALC_DEPTH,
  parameter int ADDR_W = CALC_ADDR_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     in_range,
  input  logic [ADDR_W-1:0]        addr,
  input  logic signed [DATA_W-1:0] data,
  output logic                     busy,
  output logic                     we,
  output logic [ADDR_W-1:0]        waddr,
  output logic signed [DATA_W-1:0] wdata
);

  localparam logic [ADDR_W:0] LAST    = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

  mem_state_e        state;
  logic [ADDR_W:0]   ptr;
  logic              clearing;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_CLEAR;
      ptr   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          if (ptr == LAST) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            ptr   <= '0;
          end else begin
            ptr <= ptr + PTR_ONE;
          end
        end
        ST_IDLE: begin
          if (clr) begin
            state <= ST_CLEAR;
            busy  <= 1'b1;
            ptr   <= '0;
          end
        end
        default: begin
          state <= ST_CLEAR;
          busy  <= 1'b1;
          ptr   <= '0;
        end
      endcase
    end
  end

  // The array is never touched while reset is held, even mid-clear.
  always_comb begin
    clearing = (state == ST_CLEAR);
    we       = rst && (clearing || (en && !clr && in_range));
    waddr    = clearing ? ptr[ADDR_W-1:0] : addr;
    wdata    = clearing ? '0 : data;
  end

endmodule

// File: rtl/data_memory_sync.sv
// rtl/data_memory_sync.sv - single-port data RAM with registered read and clear engine
module data_memory_sync
  import calc_mem_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int DEPTH  = CALC_DEPTH,
  parameter int ADDR_W = CALC_ADDR_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     EN,
  input  logic                     RD_EN,
  input  logic                     CLR,
  input  logic [ADDR_W-1:0]        ADDR,
  input  logic signed [DATA_W-1:0] IN,
  output logic signed [DATA_W-1:0] OUT,
  output logic                     OUT_VALID,
  output logic                     BUSY,
  output logic                     ERR
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic signed [DATA_W-1:0] ram [DEPTH];
  logic                     in_range;
  logic                     accept;
  logic                     rd_ok;
  logic                     err_next;
  logic                     we;
  logic [ADDR_W-1:0]        waddr;
  logic signed [DATA_W-1:0] wdata;

  always_comb begin
    in_range = ({1'b0, ADDR} < DEPTH_L);
    accept   = !BUSY && !CLR;
    rd_ok    = accept && RD_EN && in_range;
    err_next = accept && (EN || RD_EN) && !in_range;
  end

  mem_clear_fsm #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk      (CLK),
    .rst      (RST),
    .clr      (CLR),
    .en       (EN),
    .in_range (in_range),
    .addr     (ADDR),
    .data     (IN),
    .busy     (BUSY),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata)
  );

  always_ff @(posedge CLK) begin
    if (we) ram[waddr] <= wdata;
  end

  // Write-first: a same-cycle write forwards IN straight to the read register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      OUT       <= '0;
      OUT_VALID <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      OUT_VALID <= rd_ok;
      ERR       <= err_next;
      if (rd_ok) OUT <= EN ? IN : ram[ADDR];
    end
  end

endmodule

// File: tb/tb_data_memory_sync.sv
// tb/tb_data_memory_sync.sv - directed bench for data_memory_sync (default and DEPTH=300)
module tb_data_memory_sync;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               rd_en;
  logic               clr;
  logic [8:0]         addr;
  logic signed [15:0] din;
  logic signed [15:0] out_b, out_s;
  logic               valid_b, valid_s, busy_b, busy_s, err_b, err_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_memory_sync u_dut (
    .CLK(clk), .RST(rst), .EN(en), .RD_EN(rd_en), .CLR(clr), .ADDR(addr), .IN(din),
    .OUT(out_b), .OUT_VALID(valid_b), .BUSY(busy_b), .ERR(err_b)
  );

  data_memory_sync #(.DATA_W(16), .DEPTH(300), .ADDR_W(9)) u_small (
    .CLK(clk), .RST(rst), .EN(en), .RD_EN(rd_en), .CLR(clr), .ADDR(addr), .IN(din),
    .OUT(out_s), .OUT_VALID(valid_s), .BUSY(busy_s), .ERR(err_s)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    en = 1'b0; rd_en = 1'b0; clr = 1'b0; addr = '0; din = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    repeat (3) tick();
    total++; if (out_b !== 16'sd0) begin bad++; $display("FAIL reset_out got %0d want 0", out_b); end
    total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", valid_b); end
    total++; if (err_b !== 1'b0) begin bad++; $display("FAIL reset_err got %b want 0", err_b); end
    total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL reset_busy got %b want 1", busy_b); end
    total++; if (busy_s !== 1'b1) begin bad++; $display("FAIL reset_busy_small got %b want 1", busy_s); end
  endtask

  task automatic test_clear_time();
    int cnt_b = 0;
    int cnt_s = 0;
    int guard = 0;
    rst = 1'b1;
    while ((busy_b || busy_s) && guard < 2000) begin
      if (busy_b) cnt_b++;
      if (busy_s) cnt_s++;
      guard++;
      tick();
    end
    total++; if (cnt_b !== 512) begin bad++; $display("FAIL clear_cycles got %0d want 512", cnt_b); end
    total++; if (cnt_s !== 300) begin bad++; $display("FAIL clear_cycles_small got %0d want 300", cnt_s); end
  endtask

  task automatic read_check(input logic [8:0] a, input logic signed [15:0] exp, input string name);
    addr = a; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (valid_b !== 1'b1) begin bad++; $display("FAIL %s_valid got %b want 1", name, valid_b); end
    total++; if (out_b !== exp) begin bad++; $display("FAIL %s_out got %0d want %0d", name, out_b, exp); end
  endtask

  task automatic write_word(input logic [8:0] a, input logic signed [15:0] d);
    addr = a; din = d; en = 1'b1;
    tick();
    en = 1'b0;
  endtask

  task automatic test_read_cleared();
    read_check(9'd0,   16'sd0, "clr_rd0");
    read_check(9'd255, 16'sd0, "clr_rd255");
    read_check(9'd511, 16'sd0, "clr_rd511");
    tick();
    total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL valid_one_cycle got %b want 0", valid_b); end
  endtask

  task automatic test_write_read();
    write_word(9'd10, 16'sh7FFF);
    write_word(9'd11, -16'sd1);
    read_check(9'd10, 16'sd32767, "wr_rd10");
    read_check(9'd11, -16'sd1,    "wr_rd11");
    tick();
    total++; if (out_b !== -16'sd1) begin bad++; $display("FAIL out_hold got %0d want -1", out_b); end
  endtask

  task automatic test_write_first();
    addr = 9'd20; din = 16'sh1234; en = 1'b1; rd_en = 1'b1;
    tick();
    idle_inputs();
    total++; if (valid_b !== 1'b1) begin bad++; $display("FAIL wf_valid got %b want 1", valid_b); end
    total++; if (out_b !== 16'sh1234) begin bad++; $display("FAIL wf_out got %0h want 1234", out_b); end
  endtask

  task automatic test_out_of_range();
    logic signed [15:0] prev;
    write_word(9'd44, 16'sh0444);
    addr = 9'd44; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    prev = 16'sh0444;
    total++; if (out_s !== prev) begin bad++; $display("FAIL oor_pre_out got %0h want 0444", out_s); end
    addr = 9'd300; din = 16'sh5555; en = 1'b1;
    tick();
    en = 1'b0;
    total++; if (err_s !== 1'b1) begin bad++; $display("FAIL oor_wr_err got %b want 1", err_s); end
    total++; if (err_b !== 1'b0) begin bad++; $display("FAIL oor_wr_err_big got %b want 0", err_b); end
    tick();
    total++; if (err_s !== 1'b0) begin bad++; $display("FAIL oor_err_pulse got %b want 0", err_s); end
    addr = 9'd300; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (err_s !== 1'b1) begin bad++; $display("FAIL oor_rd_err got %b want 1", err_s); end
    total++; if (valid_s !== 1'b0) begin bad++; $display("FAIL oor_rd_valid got %b want 0", valid_s); end
    total++; if (out_s !== prev) begin bad++; $display("FAIL oor_rd_out got %0h want %0h", out_s, prev); end
    total++; if (out_b !== 16'sh5555) begin bad++; $display("FAIL big_rd300 got %0h want 5555", out_b); end
    addr = 9'd44; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    total++; if (out_s !== 16'sh0444) begin bad++; $display("FAIL alias44 got %0h want 0444", out_s); end
    total++; if (err_s !== 1'b0) begin bad++; $display("FAIL alias44_err got %b want 0", err_s); end
  endtask

  task automatic test_clr();
    int cnt = 0;
    int seen_valid = 0;
    for (int i = 0; i < 4; i++) write_word(9'(i), 16'sd5);
    read_check(9'd3, 16'sd5, "fill3");
    clr = 1'b1; en = 1'b1; addr = 9'd0; din = 16'sd9;
    tick();
    idle_inputs();
    total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL clr_valid got %b want 0", valid_b); end
    rd_en = 1'b1; addr = 9'd7;
    while (busy_b && cnt < 2000) begin
      cnt++;
      if (valid_b) seen_valid++;
      tick();
    end
    rd_en = 1'b0;
    total++; if (cnt !== 512) begin bad++; $display("FAIL clr_cycles got %0d want 512", cnt); end
    total++; if (seen_valid !== 0) begin bad++; $display("FAIL busy_valid got %0d want 0", seen_valid); end
    for (int i = 0; i < 4; i++) read_check(9'(i), 16'sd0, "clr_zero");
  endtask

  task automatic test_reset_mid_clear();
    int cnt = 0;
    int seen_valid = 0;
    addr = 9'd1; rd_en = 1'b1; rst = 1'b0;
    tick();
    total++; if (valid_b !== 1'b0) begin bad++; $display("FAIL rst_rd_valid got %b want 0", valid_b); end
    rst = 1'b1;
    repeat (100) tick();
    total++; if (busy_b !== 1'b1) begin bad++; $display("FAIL mid_busy got %b want 1", busy_b); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    while (busy_b && cnt < 2000) begin
      cnt++;
      if (valid_b) seen_valid++;
      tick();
    end
    rd_en = 1'b0;
    total++; if (cnt !== 512) begin bad++; $display("FAIL restart_cycles got %0d want 512", cnt); end
    total++; if (seen_valid !== 0) begin bad++; $display("FAIL restart_valid got %0d want 0", seen_valid); end
    read_check(9'd10, 16'sd0, "post_rst10");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_clear_time();
    test_read_cleared();
    test_write_read();
    test_write_first();
    test_out_of_range();
    test_clr();
    test_reset_mid_clear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
